// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor: FSM states and width constants.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_fadd.sv
// Single-bit full-adder cell shared with the ripple-carry adder datapath.
module fadd (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic s,
   output logic c
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per cycle through one fadd cell,
// with a start/busy/done handshake and fully registered outputs.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);

   sub_state_t       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             sum_bit;
   logic             carry_nxt;

   // Subtraction as a + ~b + ~borrow_in: invert the subtrahend bit on its way in.
   fadd u_fadd (
      .x (a_sr[0]),
      .y (~b_sr[0]),
      .z (carry),
      .s (sum_bit),
      .c (carry_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         diff_sr    <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            SHIFT: begin
               carry   <= carry_nxt;
               diff_sr <= {sum_bit, diff_sr[WIDTH-1:1]};
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               if (cnt == CW'(WIDTH - 1)) begin
                  // carry still holds the carry into the MSB on this last bit
                  diff       <= {sum_bit, diff_sr[WIDTH-1:1]};
                  borrow_out <= ~carry_nxt;
                  overflow   <= carry ^ carry_nxt;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= ~borrow_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, handshake/reset sequences, random ops.
module tb_serial_subtractor;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         overflow;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vbin;
      logic [W-1:0] ed;
      logic         ebo;
      logic         eov;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   task automatic model(input int ia, input int ib, input int ibin,
                        output int d, output int bo, output int ov);
      int raw, sa, sb, sres;
      raw  = ia - ib - ibin;
      d    = ((raw % (1 << W)) + (1 << W)) % (1 << W);
      bo   = (raw < 0) ? 1 : 0;
      sa   = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
      sb   = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
      sres = sa - sb - ibin;
      ov   = (sres < -(1 << (W - 1)) || sres > (1 << (W - 1)) - 1) ? 1 : 0;
   endtask

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
      @(negedge clk);
      a = ia; b = ib; borrow_in = ibin; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      for (int k = 0; k < 4 * W; k++) begin
         @(posedge clk);
         #1;
         edges++;
         if (done) break;
      end
      if (!done) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] ed,
                               input logic ebo, input logic eov);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_borrow"}, 32'(borrow_out), 32'(ebo));
      chk({tag, "_ovf"}, 32'(overflow), 32'(eov));
   endtask

   initial begin
      int edges, md, mbo, mov, pulses;
      logic [W-1:0] ra, rb;
      logic rbin;

      tbl[0] = '{va: 4'd7, vb: 4'd3, vbin: 1'b0, ed: 4'h4, ebo: 1'b0, eov: 1'b0};
      tbl[1] = '{va: 4'd3, vb: 4'd7, vbin: 1'b0, ed: 4'hC, ebo: 1'b1, eov: 1'b0};
      tbl[2] = '{va: 4'd8, vb: 4'd1, vbin: 1'b0, ed: 4'h7, ebo: 1'b0, eov: 1'b1};
      tbl[3] = '{va: 4'd0, vb: 4'd8, vbin: 1'b0, ed: 4'h8, ebo: 1'b1, eov: 1'b1};
      tbl[4] = '{va: 4'd15, vb: 4'd0, vbin: 1'b1, ed: 4'hE, ebo: 1'b0, eov: 1'b0};
      tbl[5] = '{va: 4'd7, vb: 4'd8, vbin: 1'b0, ed: 4'hF, ebo: 1'b1, eov: 1'b1};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      check_result("rst", 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         issue(tbl[i].va, tbl[i].vb, tbl[i].vbin);
         chk("busy_after_accept", 32'(busy), 32'd1);
         wait_done(edges);
         chk("latency", 32'(edges), 32'(W));
         chk("busy_at_done", 32'(busy), 32'd0);
         check_result($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ebo, tbl[i].eov);
         @(posedge clk);
         #1;
         chk("done_pulse", 32'(done), 32'd0);
         chk("diff_held", 32'(diff), 32'(tbl[i].ed));
      end

      // Back-to-back: start in the DONE cycle
      issue(4'd0, 4'd0, 1'b1);
      wait_done(edges);
      check_result("b2b_first", 4'hF, 1'b1, 1'b0);
      a = 4'd5; b = 4'd5; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_low", 32'(done), 32'd0);
      chk("b2b_diff_held", 32'(diff), 32'hF);
      wait_done(edges);
      chk("b2b_latency", 32'(edges), 32'(W));
      check_result("b2b_second", 4'h0, 1'b0, 1'b0);

      // start during SHIFT is ignored
      issue(4'd6, 4'd3, 1'b0);
      @(negedge clk);
      a = 4'd9; b = 4'd2; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(edges);
      chk("ign_latency", 32'(edges + 1), 32'(W));
      check_result("ign", 4'h3, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("ign_idle_busy", 32'(busy), 32'd0);
      repeat (W + 1) @(posedge clk);
      #1;
      chk("ign_no_done", 32'(done), 32'd0);

      // Asynchronous reset mid-operation after a result with both flags set
      issue(4'd7, 4'd8, 1'b0);
      wait_done(edges);
      check_result("pre_rst", 4'hF, 1'b1, 1'b1);
      issue(4'd7, 4'd3, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      check_result("mid_rst", 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 3 * W; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) pulses++;
      end
      chk("post_rst_quiet", 32'(pulses), 32'd0);

      // Random operations against the reference model
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
         model(int'(ra), int'(rb), int'(rbin), md, mbo, mov);
         issue(ra, rb, rbin);
         wait_done(edges);
         chk("rnd_latency", 32'(edges), 32'(W));
         check_result("rnd", W'(md), 1'(mbo), 1'(mov));
         if ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: computes diff = a − b − borrow_in over WIDTH clock cycles using a single full-adder cell and a carry flip-flop. It is the subtract direction of the datapath's ripple-carry adder, traded for area: one adder bit reused per cycle instead of WIDTH instances. It sits beside the parallel adder in the arithmetic unit and is driven by a start/busy/done handshake.

## Interface
- WIDTH, 4, operand and result width in bits; WIDTH ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the unit is ready (IDLE or DONE).
- a  in  WIDTH  minuend; captured on the accepting edge.
- b  in  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  in  1  borrow into bit 0; captured on the accepting edge.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; result outputs are valid.
- diff  out  WIDTH  result; held from done until the next accepted start.
- borrow_out  out  1  unsigned borrow (a < b + borrow_in).
- overflow  out  1  signed two's-complement overflow.

## Operation
- Arithmetic: diff = a + ~b + ~borrow_in, mod 2^WIDTH. The carry flop is loaded with ~borrow_in. Each cycle, fadd(x = a_sr[0], y = ~b_sr[0], z = carry) produces sum and carry-out. The sum shifts into diff_sr at the MSB. a_sr and b_sr shift right.
- borrow_out = ~(final carry-out).
- overflow = carry into the MSB XOR carry out of the MSB. Capture the carry-in on the MSB cycle.
- FSM states:
  - IDLE: not busy. On start, capture operands, clear the bit counter, load carry → SHIFT.
  - SHIFT: busy = 1. One bit per cycle; counter runs 0..WIDTH−1. After the bit WIDTH−1 edge → DONE.
  - DONE: done = 1 for this cycle only. On start, capture new operands → SHIFT (back-to-back). Otherwise → IDLE.
- start while busy (SHIFT) is ignored. Operand changes during SHIFT have no effect.
- diff, borrow_out and overflow update only on the edge that enters DONE. They are stable otherwise.
- Reset (asynchronous, including mid-operation) forces: state IDLE, busy 0, done 0, diff 0, borrow_out 0, overflow 0. The counter, shift registers and carry flop are cleared. No partial result is ever presented.

## Timing
- Accepting edge E: start = 1 while in IDLE/DONE.
- Bit i is processed on edge E+1+i, for i = 0..WIDTH−1.
- busy is high in the cycles after E through edge E+WIDTH.
- done is high in the cycle after edge E+WIDTH, i.e. latency WIDTH+1 edges from start to done. For WIDTH = 4, done is seen 5 edges after start.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared arithmetic package holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - a counter-width constant, $clog2(WIDTH).
- Sub-module: the team's existing fadd full-adder cell (ports x, y, z, s, c), instantiated once. Do not re-implement the sum/carry logic inline.
- Everything else (shift registers, counter, FSM, flags) lives in serial_subtractor.

## Test plan
- a = 7, b = 3, borrow_in = 0 → done 5 edges after start; diff = 4, borrow_out = 0, overflow = 0.
- a = 3, b = 7, borrow_in = 0 → diff = 0xC, borrow_out = 1, overflow = 0.
- a = 8, b = 1, borrow_in = 0 (−8 − 1) → diff = 7, borrow_out = 0, overflow = 1.
- a = 0, b = 0, borrow_in = 1 → diff = 0xF, borrow_out = 1, overflow = 0. Then assert start in the DONE cycle with a = 5, b = 5 → accepted back-to-back; diff = 0 with no idle cycle between.
- Handshake and reset:
  - Pulse start (a = 9, b = 2) during SHIFT → ignored; the in-flight result is unchanged.
  - Drop rst_n asynchronously at bit 2 → busy, done, diff and flags go to 0 immediately.
  - Release rst_n → IDLE. No done pulse until a new start is issued.
